// File: rtl/hdma.sv
// Colour-mode VRAM DMA engine: copies fixed-size blocks from the source bus into VRAM,
// either as one general-purpose burst or one block per PPU horizontal blank.
module hdma #(
    parameter int unsigned BLOCK_BYTES = 16,
    parameter logic [15:0] MMIO_BASE   = 16'hFF51
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_mmio_a,
    input  logic [7:0]  i_mmio_din,
    input  logic        i_mmio_wr,
    output logic [7:0]  o_mmio_dout,
    input  logic        i_hblank,
    input  logic        i_lcd_on,
    output logic [15:0] o_src_a,
    output logic        o_src_rd,
    input  logic [7:0]  i_src_din,
    output logic [12:0] o_vram_a,
    output logic        o_vram_wr,
    output logic [7:0]  o_vram_dout,
    output logic        o_occupy_extbus,
    output logic        o_occupy_vidbus,
    output logic        o_cpu_stall
);

    localparam int unsigned CntW = (BLOCK_BYTES > 2) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [CntW-1:0] LastByte = CntW'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGpRun,
        StHbWait,
        StHbRun
    } state_e;

    state_e            r_state;
    logic [15:0]       r_src;
    logic [12:0]       r_dst;
    logic [6:0]        r_rem;
    logic              r_cancelled;
    logic              r_hblank_q;
    logic              r_phase;     // 0 = source read, 1 = VRAM write
    logic [CntW-1:0]   r_byte_cnt;

    logic w_sel1;
    logic w_sel2;
    logic w_sel3;
    logic w_sel4;
    logic w_sel5;
    logic w_wr5;
    logic w_hb_rise;
    logic w_running;

    assign w_sel1    = (i_mmio_a == MMIO_BASE);
    assign w_sel2    = (i_mmio_a == MMIO_BASE + 16'd1);
    assign w_sel3    = (i_mmio_a == MMIO_BASE + 16'd2);
    assign w_sel4    = (i_mmio_a == MMIO_BASE + 16'd3);
    assign w_sel5    = (i_mmio_a == MMIO_BASE + 16'd4);
    assign w_wr5     = i_mmio_wr & w_sel5;
    assign w_hb_rise = i_hblank & ~r_hblank_q;
    assign w_running = (r_state == StGpRun) || (r_state == StHbRun);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_src       <= 16'h0000;
            r_dst       <= 13'h0000;
            r_rem       <= 7'h7F;
            r_cancelled <= 1'b0;
            r_hblank_q  <= 1'b0;
            r_phase     <= 1'b0;
            r_byte_cnt  <= '0;
        end else begin
            r_hblank_q <= i_hblank;

            // Address registers are only writable while nothing is in flight.
            if (i_mmio_wr && r_state == StIdle) begin
                if (w_sel1) r_src[15:8] <= i_mmio_din;
                if (w_sel2) r_src[7:0]  <= {i_mmio_din[7:4], 4'h0};
                if (w_sel3) r_dst[12:8] <= i_mmio_din[4:0];
                if (w_sel4) r_dst[7:0]  <= {i_mmio_din[7:4], 4'h0};
            end

            unique case (r_state)
                StIdle: begin
                    if (w_wr5) begin
                        r_rem       <= i_mmio_din[6:0];
                        r_cancelled <= 1'b0;
                        r_phase     <= 1'b0;
                        r_byte_cnt  <= '0;
                        if (!i_mmio_din[7]) begin
                            r_state <= StGpRun;
                        end else if (!i_lcd_on) begin
                            r_state <= StHbRun;
                        end else begin
                            r_state <= StHbWait;
                        end
                    end
                end
                StHbWait: begin
                    // A register write takes priority over a coincident hblank edge.
                    if (w_wr5) begin
                        if (!i_mmio_din[7]) begin
                            r_state     <= StIdle;
                            r_cancelled <= 1'b1;
                        end else begin
                            r_rem   <= i_mmio_din[6:0];
                            r_state <= i_lcd_on ? StHbWait : StHbRun;
                        end
                    end else if (w_hb_rise && i_lcd_on) begin
                        r_state <= StHbRun;
                    end
                end
                StGpRun, StHbRun: begin
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_phase    <= 1'b0;
                        r_src      <= r_src + 16'd1;
                        r_dst      <= r_dst + 13'd1;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == LastByte) begin
                            // rem wraps 0 -> 7F on completion, which is the idle read value.
                            r_rem <= r_rem - 7'd1;
                            if (r_rem == 7'd0) begin
                                r_state <= StIdle;
                            end else if (r_state == StHbRun) begin
                                r_state <= StHbWait;
                            end
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_mmio_dout = 8'hFF;
        if (w_sel5) begin
            if (r_state != StIdle) begin
                o_mmio_dout = {1'b0, r_rem};
            end else if (r_cancelled) begin
                o_mmio_dout = {1'b1, r_rem};
            end
        end
    end

    assign o_src_a         = r_src;
    assign o_vram_a        = r_dst;
    assign o_vram_dout     = i_src_din;
    assign o_src_rd        = w_running & ~r_phase;
    assign o_vram_wr       = w_running & r_phase;
    assign o_occupy_extbus = w_running & ~r_phase;
    assign o_occupy_vidbus = w_running;
    assign o_cpu_stall     = w_running;

endmodule
